// File: rtl/enigma_ps2_pkg.sv
// Shared definitions for the PS/2 set-2 to ASCII decoder: scan constants,
// decoder FSM states, ASCII control codes and the make-code lookup.
package enigma_ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } ps2_state_e;

  // Returns the ASCII code for a make code, or 8'h00 when unmapped.
  // Letters come out uppercase when 'upper' is set, lowercase otherwise.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       upper);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: ch = 8'h41; // A
      8'h32: ch = 8'h42; // B
      8'h21: ch = 8'h43; // C
      8'h23: ch = 8'h44; // D
      8'h24: ch = 8'h45; // E
      8'h2B: ch = 8'h46; // F
      8'h34: ch = 8'h47; // G
      8'h33: ch = 8'h48; // H
      8'h43: ch = 8'h49; // I
      8'h3B: ch = 8'h4A; // J
      8'h42: ch = 8'h4B; // K
      8'h4B: ch = 8'h4C; // L
      8'h3A: ch = 8'h4D; // M
      8'h31: ch = 8'h4E; // N
      8'h44: ch = 8'h4F; // O
      8'h4D: ch = 8'h50; // P
      8'h15: ch = 8'h51; // Q
      8'h2D: ch = 8'h52; // R
      8'h1B: ch = 8'h53; // S
      8'h2C: ch = 8'h54; // T
      8'h3C: ch = 8'h55; // U
      8'h2A: ch = 8'h56; // V
      8'h1D: ch = 8'h57; // W
      8'h22: ch = 8'h58; // X
      8'h35: ch = 8'h59; // Y
      8'h1A: ch = 8'h5A; // Z
      default: begin
        letter = 1'b0;
        case (code)
          8'h45: ch = 8'h30;
          8'h16: ch = 8'h31;
          8'h1E: ch = 8'h32;
          8'h26: ch = 8'h33;
          8'h25: ch = 8'h34;
          8'h2E: ch = 8'h35;
          8'h36: ch = 8'h36;
          8'h3D: ch = 8'h37;
          8'h3E: ch = 8'h38;
          8'h46: ch = 8'h39;
          8'h29: ch = ASCII_SP;
          8'h5A: ch = ASCII_CR;
          8'h66: ch = ASCII_BS;
          default: ch = 8'h00;
        endcase
      end
    endcase
    if (letter && !upper) begin
      ch = ch + 8'h20;
    end
    return ch;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous first-word-fall-through FIFO. data_o shows the head entry
// while non-empty and zero when empty. A push while full is accepted only
// if a pop happens in the same cycle.
module char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until the count covers them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan byte stream to ASCII character FIFO.
// Tracks break/extended prefixes, Shift and Caps Lock, and buffers the
// produced characters behind a valid/ready interface.
// Optional macro ENIGMA_REPEAT_FILTER_EN suppresses typematic repeats of
// the last emitting key until its break code arrives.
module ps2_ascii_decoder
  import enigma_ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LETTERS_ONLY = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  output logic [7:0]                      ascii_data,
  output logic                            ascii_valid,
  input  logic                            ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            shift_active,
  output logic                            caps_lock,
  output logic                            overflow
);

  ps2_state_e state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       overflow_q, overflow_d;
  logic       make_valid, break_valid;
  logic       upper;
  logic [7:0] mapped;
  logic       char_req, filter_drop, push_req;
  logic       fifo_full, fifo_empty, pop;

  assign shift_active = lshift_q | rshift_q;
  assign caps_lock    = caps_q;
  assign overflow     = overflow_q;
  assign ascii_valid  = !fifo_empty;
  assign pop          = ascii_valid && ascii_ready;

  // Prefix FSM plus Shift/Caps tracking; advances only on strobed bytes.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    make_valid  = 1'b0;
    break_valid = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else begin
            make_valid = 1'b1;
            if (scan_code == SC_LSHIFT) lshift_d = 1'b1;
            if (scan_code == SC_RSHIFT) rshift_d = 1'b1;
            if (scan_code == SC_CAPS)   caps_d   = ~caps_q;
          end
        end
        BREAK: begin
          if (scan_code != SC_BREAK) begin
            state_d     = IDLE;
            break_valid = 1'b1;
            if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
            if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
          end
        end
        EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = EXT_BREAK;
          end else if (scan_code != SC_EXT) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Character lookup uses the Shift/Caps state from before this byte.
  always_comb begin
    upper  = (LETTERS_ONLY != 0) ? 1'b1 : (shift_active ^ caps_q);
    mapped = scan_to_ascii(scan_code, upper);
    if ((LETTERS_ONLY != 0) && !(mapped >= 8'h41 && mapped <= 8'h5A)) begin
      mapped = 8'h00;
    end
    char_req = make_valid && (mapped != 8'h00);
  end

`ifdef ENIGMA_REPEAT_FILTER_EN
  logic [7:0] held_code_q, held_code_d;
  logic       held_q, held_d;

  // Typematic filter: drop a make matching the still-held emitting key.
  always_comb begin
    held_code_d = held_code_q;
    held_d      = held_q;
    filter_drop = 1'b0;
    if (char_req) begin
      if (held_q && (scan_code == held_code_q)) begin
        filter_drop = 1'b1;
      end else begin
        held_code_d = scan_code;
        held_d      = 1'b1;
      end
    end else if (break_valid && held_q && (scan_code == held_code_q)) begin
      held_d = 1'b0;
    end
  end

  // Held-key register.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_code_q <= '0;
      held_q      <= 1'b0;
    end else begin
      held_code_q <= held_code_d;
      held_q      <= held_d;
    end
  end
`else
  assign filter_drop = 1'b0;
`endif

  assign push_req   = char_req && !filter_drop;
  assign overflow_d = overflow_q | (push_req && fifo_full && !pop);

  // Decoder state registers; overflow is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      caps_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      caps_q     <= caps_d;
      overflow_q <= overflow_d;
    end
  end

  char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_req),
    .pop_i   (pop),
    .data_i  (mapped),
    .data_o  (ascii_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed self-checking bench for ps2_ascii_decoder (FIFO_DEPTH=4).
module tb_ps2_ascii_decoder;

  logic       clock;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready;
  logic [2:0] fifo_count;
  logic       shift_active;
  logic       caps_lock;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ps2_ascii_decoder #(
    .FIFO_DEPTH   (4),
    .LETTERS_ONLY (0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .ascii_data   (ascii_data),
    .ascii_valid  (ascii_valid),
    .ascii_ready  (ascii_ready),
    .fifo_count   (fifo_count),
    .shift_active (shift_active),
    .caps_lock    (caps_lock),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Strobe one byte; returns #1 after the edge that captured it.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(ascii_valid), 32'd1);
    check({tag, "_data"}, 32'(ascii_data), 32'(exp));
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_rep;
    reset       = 1'b1;
    scan_code   = 8'h00;
    scan_valid  = 1'b0;
    ascii_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_data", 32'(ascii_data), 32'h00);
    check("rst_valid", 32'(ascii_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_shift", 32'(shift_active), 32'd0);
    check("rst_caps", 32'(caps_lock), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single make: one-cycle latency, then drains
    send(8'h1C);
    check("a_valid", 32'(ascii_valid), 32'd1);
    check("a_data", 32'(ascii_data), 32'h61);
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
    check("a_drained", 32'(ascii_valid), 32'd0);
    check("a_empty_data", 32'(ascii_data), 32'h00);

    // Shift
    send(8'h12);
    check("shift_on", 32'(shift_active), 32'd1);
    send(8'h1C);
    send(8'hF0);
    check("shift_still", 32'(shift_active), 32'd1);
    send(8'h12);
    check("shift_off", 32'(shift_active), 32'd0);
    send(8'h1C);
    check("shift_count", 32'(fifo_count), 32'd2);
    pop_expect("shA", 8'h41);
    pop_expect("sha", 8'h61);

    // Right shift tracked independently
    send(8'h59);
    send(8'h12);
    send(8'hF0);
    send(8'h12);
    check("rshift_held", 32'(shift_active), 32'd1);
    send(8'hF0);
    send(8'h59);
    check("rshift_off", 32'(shift_active), 32'd0);

    // Caps lock with and without shift
    send(8'h58);
    check("caps_on", 32'(caps_lock), 32'd1);
    send(8'h32);
    send(8'h12);
    send(8'h32);
    check("caps_still", 32'(caps_lock), 32'd1);
    pop_expect("capsB", 8'h42);
    pop_expect("capsb", 8'h62);
    send(8'hF0);
    send(8'h12);
    send(8'h58);
    check("caps_off", 32'(caps_lock), 32'd0);
    check("caps_empty", 32'(fifo_count), 32'd0);

    // Extended and break sequences produce nothing
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h1C);
    check("ext_count", 32'(fifo_count), 32'd0);
    send(8'h29);
    pop_expect("space", 8'h20);

    // Enter, backspace, digits (shifted digit stays a digit), unmapped
    send(8'h5A); send(8'h66); send(8'h45);
    pop_expect("enter", 8'h0D);
    pop_expect("bksp", 8'h08);
    pop_expect("dig0", 8'h30);
    send(8'h12); send(8'h46); send(8'hF0); send(8'h12);
    pop_expect("dig9", 8'h39);
    send(8'h05);
    check("unmapped", 32'(fifo_count), 32'd0);

    // Overflow: six makes into depth 4
    send(8'h1C); send(8'h32); send(8'h21);
    send(8'h23); send(8'h24); send(8'h2B);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(ascii_data), 32'h61);
    ascii_ready = 1'b1;
    send(8'h34);
    ascii_ready = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd1);
    pop_expect("ovf_b", 8'h62);
    pop_expect("ovf_c", 8'h63);
    pop_expect("ovf_d", 8'h64);
    pop_expect("ovf_g", 8'h67);
    check("ovf_drained", 32'(ascii_valid), 32'd0);

    // Typematic repeats
`ifdef ENIGMA_REPEAT_FILTER_EN
    exp_rep = 2;
`else
    exp_rep = 4;
`endif
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    check("rep_count", 32'(fifo_count), 32'(exp_rep));
    for (int i = 0; i < exp_rep; i++) begin
      pop_expect("rep_a", 8'h61);
    end
    check("rep_drained", 32'(ascii_valid), 32'd0);

    // Reset mid-sequence discards pending break prefix and FIFO contents
    send(8'h32);
    send(8'hF0);
    do_reset();
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    send(8'h1C);
    check("post_rst_valid", 32'(ascii_valid), 32'd1);
    check("post_rst_data", 32'(ascii_data), 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Sequential successor to the combinational scan-code-to-ASCII lookup. Consumes a stream of PS/2 set-2 scan bytes, which may include prefix bytes.
- Tracks make/break/extended prefixes, Shift and Caps Lock state, and converts make codes to ASCII (letters, digits, space, enter, backspace).
- Buffers characters in a small FIFO with a valid/ready interface toward the Enigma rotor datapath.
- Sits between the PS/2 byte receiver and the encryption core.

Parameters:
- FIFO_DEPTH, 4, number of buffered characters; power of 2, minimum 2.
- LETTERS_ONLY, 0, when 1 only A–Z are emitted (always uppercase) and all other keys are dropped (legacy Enigma mode).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- scan_code  input  8  scan byte from the PS/2 receiver.
- scan_valid  input  1  one-cycle strobe; scan_code is valid this cycle.
- ascii_data  output  8  head-of-FIFO character.
- ascii_valid  output  1  FIFO non-empty.
- ascii_ready  input  1  consumer accepts the head this cycle when ascii_valid=1.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  occupancy.
- shift_active  output  1  left (0x12) or right (0x59) Shift currently held.
- caps_lock  output  1  Caps Lock toggle state.
- overflow  output  1  sticky; a character was dropped because the FIFO was full.

Behaviour:
- Reset: one clock, synchronous, active-high, as fixed above. All outputs go to 0: ascii_data=0x00, ascii_valid=0, fifo_count=0, shift_active=0, caps_lock=0, overflow=0. FSM goes to IDLE. Reset mid-sequence discards any pending prefix and all FIFO contents.
- FSM advances only on cycles with scan_valid=1.
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is a make code, which is processed and the FSM stays in IDLE.
  - BREAK: F0 -> stay in BREAK; any other byte is a break code -> IDLE. Break of 0x12/0x59 clears that Shift's held bit; all other breaks are ignored.
  - EXT: F0 -> EXT_BREAK; E0 -> stay in EXT; any other byte -> IDLE, no output.
  - EXT_BREAK: any byte -> IDLE, no output.
- Make processing:
  - 0x12/0x59 set that Shift's held bit; left and right are tracked separately; shift_active is the OR of the two.
  - 0x58 toggles caps_lock.
  - Letters use the standard set-2 map (0x1C=A … 0x1A=Z). Uppercase when shift_active XOR caps_lock, else lowercase (+0x20). The Shift state used is the value before this byte.
  - Digits: 0x45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'. Shifted digits are still emitted as the digit.
  - 0x29 -> 0x20 (space), 0x5A -> 0x0D (enter), 0x66 -> 0x08 (backspace).
  - Unmapped make codes are dropped silently.
  - LETTERS_ONLY=1: letters are always uppercase; everything except Shift/Caps tracking is dropped.
- Typematic repeats (the same make code arriving again while the key is held) each emit a character.
- Latency: a make byte strobed in cycle N is written at the end of cycle N. ascii_valid=1 and ascii_data are valid from cycle N+1.
- FIFO:
  - Pop occurs when ascii_valid && ascii_ready.
  - Push when full and no pop: the character is dropped, overflow is set, and count is unchanged.
  - Push and pop in the same cycle while full: both happen, no drop, count unchanged.
  - Push and pop in the same cycle while empty is impossible, because ascii_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on reset.
- ascii_data is first-word-fall-through: it shows the head entry while ascii_valid=1 and 0x00 when the FIFO is empty.

Optional Feature:
- Macro: ENIGMA_REPEAT_FILTER_EN.
- Defined: a register holds the last emitting make code plus a held flag.
  - A make equal to the held code while held is dropped (typematic suppression).
  - The held flag clears on the break of that code.
  - A different emitting make replaces the held code.
  - Reset clears both the held code and the flag.
- Undefined: no filter register exists; every repeat emits.

Decomposition:
- Package enigma_ps2_pkg:
  - scan constants: SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58;
  - FSM state enum {IDLE, BREAK, EXT, EXT_BREAK};
  - ASCII constants for CR, BS, SP;
  - the lookup function scan_to_ascii(code, upper).
- Sub-module char_fifo: a synchronous FWFT FIFO parametrised by DEPTH and WIDTH, with push, pop, full, empty, count. It is instantiated once.

Test Plan:
- 0x1C, then reset deasserted idle -> cycle after the strobe: ascii_valid=1, ascii_data=0x61 'a'. With ascii_ready=1, valid drops the next cycle.
- 0x12, 0x1C, F0 0x12, 0x1C -> 'A' (0x41) then 'a' (0x61). shift_active is 1 between the Shift make and its break.
- 0x58, 0x32, 0x12, 0x32 -> 'B' (0x42) then 'b' (0x62). caps_lock=1 throughout.
- E0 0x75, E0 F0 0x75, F0 0x1C -> no output, FSM back in IDLE, fifo_count=0.
- FIFO_DEPTH=4, ascii_ready=0, six letter makes -> fifo_count=4, overflow=1, first four characters in order. Then a push on the same cycle as a pop while full -> count stays 4, no new drop.
- ENIGMA_REPEAT_FILTER_EN, 0x1C x3, F0 0x1C, 0x1C -> exactly two 'a' outputs. Without the macro: four 'a' outputs.
